ttl_counter_ud_sync: RTL and testbench

Parametrised synchronous up/down counter for TTL-replacement logic, a generalisation of the 74161/163/169/190-family counters. It runs on the single system clock and advances only on a rising edge of the clock-enable strobe Cen. It adds a programmable modulus (binary or decade), direction control, a synchronous clear, a parallel load and cascade outputs. Video timing chains and sprite/address counters instantiate it in place of discrete counter chips.

---
 rtl/ttl_counter_ud_sync.sv | 74 +++++++
 tb/tb_ttl_counter_ud_sync.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ttl_counter_ud_sync.sv
// Synchronous up/down counter with programmable modulus, sync clear, parallel load and cascade outputs.
// Define TTL_CNT_RCK_EN to add the 74191-style ripple clock output RCK_bar.
module ttl_counter_ud_sync #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             Clk,
    input  logic             Clear_bar,
    input  logic             Cen,
    input  logic             Sclr_bar,
    input  logic             Load_bar,
    input  logic             ENT,
    input  logic             ENP,
    input  logic             U_D,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
`ifdef TTL_CNT_RCK_EN
    output logic             RCK_bar,
`endif
    output logic             MAX_MIN
);

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("ttl_counter_ud_sync: MODULUS must lie in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    logic last_cen;
    logic count_event;
    logic tc;

    // last_cen resets high so a Cen held high across reset release is not an edge.
    assign count_event = Cen & ~last_cen;
    assign tc          = U_D ? (Q == MAX_Q) : (Q == '0);
    assign MAX_MIN     = tc;
    assign RCO         = ENT & tc;

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            Q        <= '0;
            last_cen <= 1'b1;
        end else begin
            last_cen <= Cen;
            if (count_event) begin
                if (!Sclr_bar) begin
                    Q <= '0;
                end else if (!Load_bar) begin
                    Q <= D;
                end else if (ENT && ENP) begin
                    if (U_D) begin
                        // Out-of-range values fold back to zero on the next up count.
                        Q <= (Q >= MAX_Q) ? '0 : Q + 1'b1;
                    end else begin
                        Q <= (Q == '0) ? MAX_Q : Q - 1'b1;
                    end
                end
            end
        end
    end

`ifdef TTL_CNT_RCK_EN
    // One-cycle low pulse following a Cen falling edge seen at terminal count.
    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            RCK_bar <= 1'b1;
        end else begin
            RCK_bar <= ~(~Cen & last_cen & ENT & tc);
        end
    end
`endif

endmodule

// File: tb/tb_ttl_counter_ud_sync.sv
// Bench for ttl_counter_ud_sync: a decade counter under directed and random stimulus,
// plus two chained 4-bit binary stages for cascade, mid-operation clear and ripple clock.
module tb_ttl_counter_ud_sync;

    localparam int W     = 4;
    localparam int M_DEC = 10;

    // clock / reset
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    // decade counter signals
    logic         d_clear_bar, d_cen, d_sclr_bar, d_load_bar, d_ent, d_enp, d_ud;
    logic [W-1:0] d_d, d_q;
    logic         d_rco, d_max_min;
`ifdef TTL_CNT_RCK_EN
    logic         d_rck_bar;
`endif

    // cascade signals
    logic         c_clear_bar, c_cen, c_ent;
    logic [W-1:0] c_q0, c_q1;
    logic         c_rco0, c_rco1, c_max_min0, c_max_min1;
`ifdef TTL_CNT_RCK_EN
    logic         c_rck_bar0, c_rck_bar1;
`endif

    ttl_counter_ud_sync #(.WIDTH(W), .MODULUS(M_DEC)) u_dec (
        .Clk(Clk), .Clear_bar(d_clear_bar), .Cen(d_cen), .Sclr_bar(d_sclr_bar),
        .Load_bar(d_load_bar), .ENT(d_ent), .ENP(d_enp), .U_D(d_ud), .D(d_d),
        .Q(d_q), .RCO(d_rco),
`ifdef TTL_CNT_RCK_EN
        .RCK_bar(d_rck_bar),
`endif
        .MAX_MIN(d_max_min)
    );

    ttl_counter_ud_sync #(.WIDTH(W), .MODULUS(16)) u_stage0 (
        .Clk(Clk), .Clear_bar(c_clear_bar), .Cen(c_cen), .Sclr_bar(1'b1),
        .Load_bar(1'b1), .ENT(c_ent), .ENP(1'b1), .U_D(1'b1), .D(4'h0),
        .Q(c_q0), .RCO(c_rco0),
`ifdef TTL_CNT_RCK_EN
        .RCK_bar(c_rck_bar0),
`endif
        .MAX_MIN(c_max_min0)
    );

    ttl_counter_ud_sync #(.WIDTH(W), .MODULUS(16)) u_stage1 (
        .Clk(Clk), .Clear_bar(c_clear_bar), .Cen(c_cen), .Sclr_bar(1'b1),
        .Load_bar(1'b1), .ENT(c_rco0), .ENP(1'b1), .U_D(1'b1), .D(4'h0),
        .Q(c_q1), .RCO(c_rco1),
`ifdef TTL_CNT_RCK_EN
        .RCK_bar(c_rck_bar1),
`endif
        .MAX_MIN(c_max_min1)
    );

    // scoreboard
    int              n_tests = 0;
    int              n_fail  = 0;
    logic [31:0]     exp_q[$];
    int              ref_q    = 0;
    int              casc_ref = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: counter rules expressed directly on integers
    function automatic int ref_next(input int q, input bit sclr_b, input bit load_b,
                                    input int d, input bit ent, input bit enp, input bit ud);
        if (!sclr_b)            return 0;
        if (!load_b)            return d;
        if (!(ent && enp))      return q;
        if (ud)                 return (q >= M_DEC - 1) ? 0 : q + 1;
        return (q == 0) ? M_DEC - 1 : q - 1;
    endfunction

    function automatic bit ref_tc(input int q, input bit ud);
        return ud ? (q == M_DEC - 1) : (q == 0);
    endfunction

    // driver: one step of the decade counter, optionally with a Cen pulse
    task automatic dec_step(input bit ev, input bit sclr_b, input bit load_b, input int d,
                            input bit ent, input bit enp, input bit ud);
        int nq;
        @(negedge Clk);
        d_sclr_bar = sclr_b; d_load_bar = load_b; d_d = W'(d);
        d_ent = ent; d_enp = enp; d_ud = ud; d_cen = ev;
        nq = ev ? ref_next(ref_q, sclr_b, load_b, d, ent, enp, ud) : ref_q;
        exp_q.push_back(32'(nq));
        ref_q = nq;
        @(negedge Clk);
        d_cen = 1'b0;
        check("dec_q", 32'(d_q), exp_q.pop_front());
        check("dec_max_min", 32'(d_max_min), 32'(ref_tc(ref_q, ud)));
        check("dec_rco", 32'(d_rco), 32'(ent && ref_tc(ref_q, ud)));
    endtask

    // driver: one Cen pulse on the cascade, then the ripple clock window
    task automatic casc_pulse();
        bit tc0;
        @(negedge Clk);
        c_cen = 1'b1;
        @(negedge Clk);
        c_cen = 1'b0;
        casc_ref = (casc_ref + 1) % 256;
        tc0 = (casc_ref % 16) == 15;
        check("casc_q", 32'({c_q1, c_q0}), 32'(casc_ref));
        check("casc_max_min0", 32'(c_max_min0), 32'(tc0));
        check("casc_rco1", 32'(c_rco1), 32'(tc0 && (casc_ref / 16) == 15));
        @(posedge Clk); #1;
`ifdef TTL_CNT_RCK_EN
        check("casc_rck_low", 32'(c_rck_bar0), 32'(!tc0));
`endif
        @(negedge Clk);
        @(posedge Clk); #1;
`ifdef TTL_CNT_RCK_EN
        check("casc_rck_high", 32'(c_rck_bar0), 32'd1);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        d_clear_bar = 1'b0; d_cen = 1'b1; d_sclr_bar = 1'b1; d_load_bar = 1'b1;
        d_ent = 1'b1; d_enp = 1'b1; d_ud = 1'b0; d_d = '0;
        c_clear_bar = 1'b0; c_cen = 1'b0; c_ent = 1'b1;

        // reset with Cen high, then release with Cen still high
        repeat (3) @(negedge Clk);
        check("rst_q", 32'(d_q), 32'd0);
        d_clear_bar = 1'b1;
        c_clear_bar = 1'b1;
        repeat (5) @(negedge Clk);
        check("idle_q", 32'(d_q), 32'd0);
        check("idle_rco_down", 32'(d_rco), 32'd1);
        d_ud = 1'b1;
        #1;
        check("idle_rco_up", 32'(d_rco), 32'd0);
        d_cen = 1'b0;
        ref_q = 0;

        // decade up count through the wrap
        for (int i = 0; i < 12; i++) dec_step(1, 1, 1, 0, 1, 1, 1);
        check("dec_up_end", 32'(d_q), 32'd2);

        // clear, then MAX_MIN at zero in down mode with ENT low
        dec_step(1, 0, 1, 0, 1, 1, 0);
        dec_step(0, 1, 1, 0, 0, 1, 0);
        dec_step(1, 1, 1, 0, 1, 1, 0);
        check("down_wrap", 32'(d_q), 32'd9);

        // priority: clear over load, load ignores ENT, ENP low holds
        dec_step(1, 0, 0, 5, 1, 1, 1);
        dec_step(1, 1, 0, 5, 0, 1, 1);
        dec_step(1, 1, 1, 5, 1, 0, 1);
        check("prio_hold", 32'(d_q), 32'd5);

        // out-of-range load
        dec_step(1, 1, 0, 12, 1, 1, 1);
        dec_step(1, 1, 1, 0, 1, 1, 1);
        check("oor_up", 32'(d_q), 32'd0);
        dec_step(1, 1, 0, 12, 1, 1, 1);
        dec_step(1, 1, 1, 0, 1, 1, 0);
        check("oor_down", 32'(d_q), 32'd11);

        // random mix, including steps without a count event
        for (int i = 0; i < 200; i++) begin
            dec_step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
                     $urandom_range(0, 5) != 0, int'($urandom_range(0, 15)),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 1) == 1);
        end

        // cascade to 0x0F, then carry into the upper stage
        casc_ref = 0;
        for (int i = 0; i < 16; i++) casc_pulse();
        check("casc_carry", 32'({c_q1, c_q0}), 32'h10);

        // asynchronous clear during Cen high
        @(negedge Clk);
        c_cen = 1'b1;
        #1 c_clear_bar = 1'b0;
        #1 check("casc_clear_now", 32'({c_q1, c_q0}), 32'd0);
        repeat (2) @(negedge Clk);
        c_clear_bar = 1'b1;
        repeat (3) @(negedge Clk);
        check("casc_clear_hold", 32'({c_q1, c_q0}), 32'd0);
        c_cen = 1'b0;
        casc_ref = 0;
        casc_pulse();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
